// File: rtl/bcd_share_arbiter_pkg.sv
// Shared constants, FSM encoding and small helpers for the time-shared
// binary-to-BCD converter.
package bcd_share_arbiter_pkg;

  localparam int c_MAX_VALUE = 99;
  localparam int c_NUM_ITER  = 7;
  localparam int c_BIN_WIDTH = 7;
  localparam int c_BCD_WIDTH = 8;
  localparam int c_CNT_WIDTH = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Two BCD digits cannot represent more than 99, so larger inputs saturate.
  function automatic logic [c_BIN_WIDTH-1:0] clamp_bin(input logic [c_BIN_WIDTH-1:0] v);
    return (v > c_BIN_WIDTH'(c_MAX_VALUE)) ? c_BIN_WIDTH'(c_MAX_VALUE) : v;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_share_arbiter_shift.sv
// Shift-add-3 (double dabble) engine: start loads a value, one iteration per
// cycle follows, done_o flags the cycle whose edge performs the last iteration.
module bcd_shift_engine
  import bcd_share_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [c_BIN_WIDTH-1:0] bin_i,
  output logic                   done_o,
  output logic [c_BCD_WIDTH-1:0] bcd_o
);

  logic [c_BIN_WIDTH-1:0] bin_q, bin_d;
  logic [c_BCD_WIDTH-1:0] bcd_q, bcd_d;
  logic [c_CNT_WIDTH-1:0] cnt_q;
  logic                   active_q;
  logic [c_BCD_WIDTH-1:0] adj;

  always_comb begin
    adj            = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    {bcd_d, bin_d} = {adj[c_BCD_WIDTH-2:0], bin_q, 1'b0};
  end

  assign done_o = active_q && (cnt_q == c_CNT_WIDTH'(c_NUM_ITER - 1));
  assign bcd_o  = bcd_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      bin_q    <= bin_i;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bcd_share_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD engine between two requesters;
// owns the grant/done pulses and the per-requester result registers.
module bcd_share_arbiter
  import bcd_share_arbiter_pkg::*;
(
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Req_0,
  input  logic [c_BIN_WIDTH-1:0] i_Bin_0,
  input  logic                   i_Req_1,
  input  logic [c_BIN_WIDTH-1:0] i_Bin_1,
  output logic                   o_Gnt_0,
  output logic                   o_Gnt_1,
  output logic                   o_Done_0,
  output logic                   o_Done_1,
  output logic [c_BCD_WIDTH-1:0] o_BCD_0,
  output logic [c_BCD_WIDTH-1:0] o_BCD_1,
  output logic                   o_Busy
);

  state_t                 state_q, state_d;
  logic                   gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                   done0_q, done0_d, done1_q, done1_d;
  logic [c_BCD_WIDTH-1:0] bcd0_q, bcd0_d, bcd1_q, bcd1_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic                   hold_q, hold_d;

  logic                   winner;
  logic                   eng_start, eng_done;
  logic [c_BIN_WIDTH-1:0] eng_bin;
  logic [c_BCD_WIDTH-1:0] eng_bcd;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    bcd0_d    = bcd0_q;
    bcd1_d    = bcd1_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    eng_start = 1'b0;
    winner    = (i_Req_0 && i_Req_1) ? ~last_q : i_Req_1;
    eng_bin   = clamp_bin(winner ? i_Bin_1 : i_Bin_0);

    case (state_q)
      // hold_q spends one idle cycle after reset and after each commit
      // before arbitrating, which spaces back-to-back grants 10 cycles apart.
      S_IDLE: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else if (i_Req_0 || i_Req_1) begin
          eng_start = 1'b1;
          gnt0_d    = ~winner;
          gnt1_d    = winner;
          owner_d   = winner;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        if (eng_done) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (owner_q) begin
          bcd1_d  = eng_bcd;
          done1_d = 1'b1;
        end else begin
          bcd0_d  = eng_bcd;
          done0_d = 1'b1;
        end
        last_d  = owner_q;
        hold_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      bcd0_q  <= '0;
      bcd1_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      bcd0_q  <= bcd0_d;
      bcd1_q  <= bcd1_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  bcd_shift_engine u_engine (
    .clk     (i_Clk),
    .rst_n   (i_Rst_L),
    .start_i (eng_start),
    .bin_i   (eng_bin),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd)
  );

  assign o_Gnt_0  = gnt0_q;
  assign o_Gnt_1  = gnt1_q;
  assign o_Done_0 = done0_q;
  assign o_Done_1 = done1_q;
  assign o_BCD_0  = bcd0_q;
  assign o_BCD_1  = bcd1_q;
  assign o_Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Scoreboard bench for bcd_share_arbiter: expected results are queued when a
// request is driven and checked, with grant/done timing, as results complete.
module tb_bcd_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [6:0] bin0, bin1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] bcd0, bcd1;

  typedef struct { logic id; logic [7:0] bcd; } exp_t;
  typedef struct { logic id; int cyc; } gnt_t;

  exp_t       sb[$];
  gnt_t       gnt_log[$];
  logic [7:0] model[2];
  int         cyc;
  int         gnt_cyc[2];
  int         last_gnt_cyc;
  bit         last_gnt_valid;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  bcd_share_arbiter dut (
    .i_Clk    (clk),
    .i_Rst_L  (rst_n),
    .i_Req_0  (req0),
    .i_Bin_0  (bin0),
    .i_Req_1  (req1),
    .i_Bin_1  (bin1),
    .o_Gnt_0  (gnt0),
    .o_Gnt_1  (gnt1),
    .o_Done_0 (done0),
    .o_Done_1 (done1),
    .o_BCD_0  (bcd0),
    .o_BCD_1  (bcd1),
    .o_Busy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: grant exclusivity/spacing, done latency, result order and values.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_gnt_valid = 1'b0;
    end else begin
      cyc++;
      if (gnt0 || gnt1) begin
        check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
        if (last_gnt_valid) check("gnt_spacing_min", 32'(cyc - last_gnt_cyc >= 9), 32'd1);
        gnt_log.push_back('{id: gnt1, cyc: cyc});
        gnt_cyc[gnt1]  = cyc;
        last_gnt_cyc   = cyc;
        last_gnt_valid = 1'b1;
      end
      if (done0 || done1) begin
        check("done_exclusive", 32'(done0 & done1), 32'd0);
        check("done_latency", 32'(cyc - gnt_cyc[done1]), 32'd8);
        check("done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("done_id", 32'(done1), 32'(e.id));
          model[e.id] = e.bcd;
        end
        check("bcd0_value", 32'(bcd0), 32'(model[0]));
        check("bcd1_value", 32'(bcd1), 32'(model[1]));
      end
    end
  end

  task automatic drive_req(input logic id, input logic v);
    if (id) req1 = v; else req0 = v;
  endtask

  task automatic wait_gnt(input logic id, input int max_cyc);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      got = id ? gnt1 : gnt0;
    end
    check(id ? "wait_gnt1" : "wait_gnt0", 32'(got), 32'd1);
  endtask

  task automatic wait_drain(input int max_cyc);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      got = (sb.size() == 0) && !busy;
    end
    check("drain", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    sb.delete();
    gnt_log.delete();
    model[0] = 8'h00; model[1] = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct { logic id; logic [6:0] bin; logic [7:0] bcd; } vec_t;
  vec_t vecs[6] = '{
    '{1'b1, 7'd127, 8'h99},
    '{1'b0, 7'd100, 8'h99},
    '{1'b0, 7'd99,  8'h99},
    '{1'b1, 7'd0,   8'h00},
    '{1'b1, 7'd58,  8'h58},
    '{1'b0, 7'd1,   8'h01}
  };

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
    model[0] = 8'h00; model[1] = 8'h00;
    cyc = 0; gnt_cyc[0] = 0; gnt_cyc[1] = 0; last_gnt_valid = 1'b0;

    // Reset state.
    #2;
    check("rst_gnt",  32'({gnt0, gnt1}), 32'd0);
    check("rst_done", 32'({done0, done1}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd0", 32'(bcd0), 32'h00);
    check("rst_bcd1", 32'(bcd1), 32'h00);

    // Single requester 0, value 42, request already pending at reset release.
    req0 = 1'b1; bin0 = 7'd42;
    sb.push_back('{1'b0, 8'h42});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("gnt_first_edge", 32'(gnt0), 32'd0);
    wait_gnt(1'b0, 5);
    req0 = 1'b0;
    wait_drain(30);
    check("single_bcd1_untouched", 32'(bcd1), 32'h00);

    // Tie after reset: requester 0 first, then requester 1.
    do_reset();
    req0 = 1'b1; bin0 = 7'd7; req1 = 1'b1; bin1 = 7'd99;
    sb.push_back('{1'b0, 8'h07});
    sb.push_back('{1'b1, 8'h99});
    wait_gnt(1'b0, 5);
    req0 = 1'b0;
    wait_gnt(1'b1, 20);
    req1 = 1'b0;
    wait_drain(30);

    // Both requests held: alternating grants, 10 cycles apart.
    gnt_log.delete();
    req0 = 1'b1; bin0 = 7'd12; req1 = 1'b1; bin1 = 7'd34;
    for (int i = 0; i < 4; i++) sb.push_back('{logic'(i % 2), (i % 2) ? 8'h34 : 8'h12});
    begin
      bit got = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
        @(negedge clk);
        got = (gnt_log.size() >= 4);
      end
      check("rr_four_grants", 32'(got), 32'd1);
    end
    req0 = 1'b0; req1 = 1'b0;
    if (gnt_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("rr_order", 32'(gnt_log[i].id), 32'(i % 2));
      for (int i = 1; i < 4; i++) check("rr_spacing", 32'(gnt_log[i].cyc - gnt_log[i-1].cyc), 32'd10);
    end
    wait_drain(40);

    // Clamping and digit boundaries with a sole requester.
    foreach (vecs[k]) begin
      if (vecs[k].id) bin1 = vecs[k].bin; else bin0 = vecs[k].bin;
      drive_req(vecs[k].id, 1'b1);
      sb.push_back('{vecs[k].id, vecs[k].bcd});
      wait_gnt(vecs[k].id, 15);
      drive_req(vecs[k].id, 1'b0);
      wait_drain(30);
    end

    // Request dropped and input changed right after grant; requester 1 held off meanwhile.
    req0 = 1'b1; bin0 = 7'd10;
    sb.push_back('{1'b0, 8'h10});
    wait_gnt(1'b0, 15);
    req0 = 1'b0; bin0 = 7'd80;
    repeat (2) @(negedge clk);
    req1 = 1'b1; bin1 = 7'd33;
    sb.push_back('{1'b1, 8'h33});
    wait_gnt(1'b1, 20);
    req1 = 1'b0;
    wait_drain(30);

    // Reset three cycles into a conversion of 55.
    req0 = 1'b1; bin0 = 7'd55;
    wait_gnt(1'b0, 15);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    model[0] = 8'h00; model[1] = 8'h00;
    #1;
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_done",  32'({done0, done1}), 32'd0);
    check("midrst_bcd0",  32'(bcd0), 32'h00);
    check("midrst_bcd1",  32'(bcd1), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_bcd0_after", 32'(bcd0), 32'h00);
    check("midrst_busy_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
